// File: rtl/decode_bid_alloc_pkg.sv
// Shared constants and types for the decode-stage branch-ID allocator.
// BIDs carry a phase bit above the BRT index so a full window can be told from an empty one.
package decode_bid_alloc_pkg;

   localparam int ENTRIES   = 8;
   localparam int BID_W     = $clog2(ENTRIES) + 1;
   localparam int BRT_IDX_W = BID_W - 1;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_t;

   // BRT slot addressed by a BID: the phase bit is dropped.
   function automatic logic [BRT_IDX_W-1:0] brt_idx(input logic [BID_W-1:0] bid);
      return bid[BRT_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/decode_bid_alloc_bid_ring_ptr.sv
// Wrapping BID pointer with increment and load; load takes priority over increment.
// Also exposes ptr+1 so callers can compare against the successor without their own adder.
module bid_ring_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] ptr,
   output logic [W-1:0] ptr_inc
);

   logic [W-1:0] ptr_reg;
   logic [W-1:0] ptr_next;

   assign ptr     = ptr_reg;
   assign ptr_inc = ptr_reg + W'(1);

   always_comb begin
      ptr_next = ptr_reg;
      if (load)
         ptr_next = load_val;
      else if (inc)
         ptr_next = ptr_inc;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         ptr_reg <= '0;
      else
         ptr_reg <= ptr_next;
   end

endmodule

// File: rtl/decode_bid_alloc.sv
// Branch-ID allocator: grants BIDs in order, frees them on in-order commit and
// rolls the allocation pointer back on an override, blocking decode until recovery ends.
module decode_bid_alloc
   import decode_bid_alloc_pkg::*;
#(
   parameter int ENTRIES_P = ENTRIES,
   parameter int BID_W_P   = BID_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_alloc_valid,
   output logic               o_alloc_ready,
   output logic [BID_W_P-1:0] o_alloc_bid,
   input  logic               i_bc_valid,
   input  logic [BID_W_P-1:0] i_bc_bid,
   input  logic               i_bco_valid,
   input  logic [BID_W_P-1:0] i_bco_bid,
   input  logic               i_recover_done,
   output logic [BID_W_P-1:0] o_count,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_recovering,
   output logic               o_err
);

   localparam logic [BID_W_P-1:0] PHASE_BIT = {1'b1, {(BID_W_P-1){1'b0}}};

   logic [BID_W_P-1:0] alloc_ptr;
   logic [BID_W_P-1:0] alloc_ptr_inc;
   logic [BID_W_P-1:0] commit_ptr;
   logic [BID_W_P-1:0] commit_ptr_inc;
   logic [BID_W_P-1:0] commit_ptr_next;
   logic [BID_W_P-1:0] bco_target;
   state_t             state_reg;
   state_t             state_next;
   logic               err_reg;
   logic               err_next;
   logic               fire;
   logic               commit_ok;
   logic               bco_bad;

   assign o_full       = (alloc_ptr ^ commit_ptr) == PHASE_BIT;
   assign o_empty      = alloc_ptr == commit_ptr;
   assign o_count      = alloc_ptr - commit_ptr;
   assign o_recovering = state_reg == RECOVER;
   assign o_err        = err_reg;
   assign o_alloc_bid  = alloc_ptr;

   // No bypass from a same-cycle commit: readiness sees only registered occupancy.
   assign o_alloc_ready = resetn & (state_reg == RUN) & ~o_full & ~i_bco_valid;
   assign fire          = i_alloc_valid & o_alloc_ready;

   assign commit_ok       = i_bc_valid & (i_bc_bid == commit_ptr) & ~o_empty;
   assign commit_ptr_next = commit_ok ? commit_ptr_inc : commit_ptr;

   // The overriding branch must already be retired, counting a commit landing this very cycle.
   assign bco_target = i_bco_bid + BID_W_P'(1);
   assign bco_bad    = i_bco_valid & (bco_target != commit_ptr_next);

   bid_ring_ptr #(.W(BID_W_P)) u_alloc_ptr (
      .clk      (clk),
      .resetn   (resetn),
      .inc      (fire),
      .load     (i_bco_valid),
      .load_val (bco_target),
      .ptr      (alloc_ptr),
      .ptr_inc  (alloc_ptr_inc)
   );

   bid_ring_ptr #(.W(BID_W_P)) u_commit_ptr (
      .clk      (clk),
      .resetn   (resetn),
      .inc      (commit_ok),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (commit_ptr),
      .ptr_inc  (commit_ptr_inc)
   );

   always_comb begin
      state_next = state_reg;
      err_next   = err_reg | (i_bc_valid & ~commit_ok) | bco_bad;
      case (state_reg)
         RUN: begin
            if (i_bco_valid)
               state_next = RECOVER;
         end
         RECOVER: begin
            if (i_recover_done && !i_bco_valid)
               state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= RUN;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= err_next;
      end
   end

endmodule

// File: tb/tb_decode_bid_alloc.sv
// Directed test of decode_bid_alloc: expected grants go into a queue that a
// negedge monitor drains on every fire; status outputs are checked inline.
module tb_decode_bid_alloc;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         resetn;
   logic         i_alloc_valid;
   logic         o_alloc_ready;
   logic [W-1:0] o_alloc_bid;
   logic         i_bc_valid;
   logic [W-1:0] i_bc_bid;
   logic         i_bco_valid;
   logic [W-1:0] i_bco_bid;
   logic         i_recover_done;
   logic [W-1:0] o_count;
   logic         o_full;
   logic         o_empty;
   logic         o_recovering;
   logic         o_err;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   decode_bid_alloc dut (
      .clk            (clk),
      .resetn         (resetn),
      .i_alloc_valid  (i_alloc_valid),
      .o_alloc_ready  (o_alloc_ready),
      .o_alloc_bid    (o_alloc_bid),
      .i_bc_valid     (i_bc_valid),
      .i_bc_bid       (i_bc_bid),
      .i_bco_valid    (i_bco_valid),
      .i_bco_bid      (i_bco_bid),
      .i_recover_done (i_recover_done),
      .o_count        (o_count),
      .o_full         (o_full),
      .o_empty        (o_empty),
      .o_recovering   (o_recovering),
      .o_err          (o_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every fire must match the oldest expected grant.
   always @(negedge clk) begin
      if (resetn && i_alloc_valid && o_alloc_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL grant: got unexpected bid %0d expected no grant", o_alloc_bid);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (o_alloc_bid != e) begin
               failures++;
               $display("FAIL grant: got bid %0d expected %0d", o_alloc_bid, e);
            end else
               $display("grant bid %0d ok", o_alloc_bid);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      i_alloc_valid = 0; i_bc_valid = 0; i_bc_bid = '0;
      i_bco_valid = 0; i_bco_bid = '0; i_recover_done = 0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 0;
      step();
      step();
      check("ready_in_reset", int'(o_alloc_ready), 0);
      resetn = 1;
      #1;
   endtask

   task automatic alloc_n(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         i_alloc_valid = 1;
         exp_q.push_back(W'(first + i));
         step();
      end
      i_alloc_valid = 0;
   endtask

   task automatic commit_n(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         i_bc_valid = 1;
         i_bc_bid   = W'(first + i);
         step();
      end
      i_bc_valid = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: fill the window
      do_reset();
      check("reset_count", int'(o_count), 0);
      check("reset_empty", int'(o_empty), 1);
      check("reset_full", int'(o_full), 0);
      check("reset_err", int'(o_err), 0);
      check("reset_recovering", int'(o_recovering), 0);
      for (int k = 0; k < 10; k++) begin
         i_alloc_valid = 1;
         if (k < 8) exp_q.push_back(W'(k));
         #1;
         check("t1_ready", int'(o_alloc_ready), (k < 8) ? 1 : 0);
         step();
      end
      i_alloc_valid = 0;
      check("t1_full", int'(o_full), 1);
      check("t1_count", int'(o_count), 8);

      // 2: commit while full frees space only next cycle
      i_alloc_valid = 1; i_bc_valid = 1; i_bc_bid = 4'd0;
      #1;
      check("t2_no_bypass", int'(o_alloc_ready), 0);
      step();
      i_bc_valid = 0;
      exp_q.push_back(4'd8);
      #1;
      check("t2_ready", int'(o_alloc_ready), 1);
      step();
      i_alloc_valid = 0;
      check("t2_count", int'(o_count), 8);
      check("t2_full", int'(o_full), 1);

      // 3: wrap with one alloc and one commit per cycle
      do_reset();
      i_alloc_valid = 1;
      exp_q.push_back(4'd0);
      step();
      for (int i = 1; i < 20; i++) begin
         exp_q.push_back(W'(i % 16));
         i_bc_valid = 1;
         i_bc_bid   = W'((i - 1) % 16);
         step();
         check("t3_count", int'(o_count), 1);
      end
      idle();
      check("t3_err", int'(o_err), 0);

      // 4: override rolls back and blocks until recovery is done
      do_reset();
      alloc_n(6, 0);
      commit_n(3, 0);
      i_bco_valid = 1; i_bco_bid = 4'd2;
      step();
      i_bco_valid = 0;
      check("t4_alloc_bid", int'(o_alloc_bid), 3);
      check("t4_count", int'(o_count), 0);
      check("t4_recovering", int'(o_recovering), 1);
      check("t4_ready", int'(o_alloc_ready), 0);
      check("t4_err", int'(o_err), 0);
      i_alloc_valid = 1; i_recover_done = 1;
      #1;
      check("t4_ready_at_done", int'(o_alloc_ready), 0);
      step();
      i_recover_done = 0;
      exp_q.push_back(4'd3);
      #1;
      check("t4_ready_after", int'(o_alloc_ready), 1);
      step();
      i_alloc_valid = 0;

      // 5: protocol errors are sticky and leave pointers alone
      do_reset();
      alloc_n(4, 0);
      commit_n(2, 0);
      i_bc_valid = 1; i_bc_bid = 4'd4;
      step();
      i_bc_valid = 0;
      check("t5_err_wrong_bid", int'(o_err), 1);
      check("t5_count", int'(o_count), 2);
      check("t5_alloc_bid", int'(o_alloc_bid), 4);
      commit_n(2, 2);
      check("t5_count_drained", int'(o_count), 0);
      check("t5_err_sticky", int'(o_err), 1);
      do_reset();
      i_bc_valid = 1; i_bc_bid = 4'd0;
      step();
      i_bc_valid = 0;
      check("t5_err_empty", int'(o_err), 1);
      check("t5_empty", int'(o_empty), 1);

      // 6: reset mid-recovery with five in flight
      do_reset();
      alloc_n(8, 0);
      i_bco_valid = 1; i_bco_bid = 4'd4;
      step();
      i_bco_valid = 0;
      check("t6_count", int'(o_count), 5);
      check("t6_recovering", int'(o_recovering), 1);
      check("t6_err_bad_bco", int'(o_err), 1);
      resetn = 0;
      step();
      check("t6_rst_count", int'(o_count), 0);
      check("t6_rst_empty", int'(o_empty), 1);
      check("t6_rst_run", int'(o_recovering), 0);
      check("t6_rst_err", int'(o_err), 0);
      check("t6_rst_ready", int'(o_alloc_ready), 0);
      resetn = 1;
      #1;
      check("t6_ready", int'(o_alloc_ready), 1);

      // 7: override beats both a fire and a recover_done
      alloc_n(2, 0);
      commit_n(1, 0);
      i_alloc_valid = 1; i_bco_valid = 1; i_bco_bid = 4'd0;
      #1;
      check("t7_ready_bco", int'(o_alloc_ready), 0);
      step();
      check("t7_recovering", int'(o_recovering), 1);
      check("t7_alloc_bid", int'(o_alloc_bid), 1);
      check("t7_err", int'(o_err), 0);
      i_recover_done = 1;
      step();
      i_bco_valid = 0;
      check("t7_stay_recover", int'(o_recovering), 1);
      step();
      idle();
      check("t7_back_to_run", int'(o_recovering), 0);
      #1;
      check("t7_ready_run", int'(o_alloc_ready), 1);

      step();
      check("grants_outstanding", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
